// File: rtl/mc_controller_ext_if.sv
// Control bundle between the multi-cycle MIPS datapath and its controller.
// master = controller side, slave = datapath side.
interface mc_controller_ext_if #(
    parameter int ALUCTRL_W = 3
);
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 zero;
    logic                 mem_ready;
    logic                 memtoreg;
    logic                 regdst;
    logic                 iord;
    logic [1:0]           pcsrc;
    logic [1:0]           alusrcb;
    logic                 alusrca;
    logic                 irwrite;
    logic                 memwrite;
    logic                 regwrite;
    logic                 pcen;
    logic                 zeroext;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 illegal;
    logic                 retire;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output memtoreg, regdst, iord, pcsrc, alusrcb, alusrca, irwrite,
               memwrite, regwrite, pcen, zeroext, alucontrol, illegal, retire
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  memtoreg, regdst, iord, pcsrc, alusrcb, alusrca, irwrite,
               memwrite, regwrite, pcen, zeroext, alucontrol, illegal, retire
    );
endinterface

// File: rtl/mc_controller_ext.sv
// Moore control FSM plus ALU decoder for the multi-cycle MIPS datapath,
// with memory wait states, illegal-instruction flag and retire pulse.
module mc_controller_ext #(
    parameter int ALUCTRL_W    = 3,
    parameter bit HAS_MEMREADY = 1'b1,
    parameter bit HAS_LOGIMM   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    mc_controller_ext_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEX,
        S_RTWB, S_BEQ, S_BNE, S_IMMEX, S_IMMWB, S_JMP
    } state_t;

    state_t state_reg;
    state_t st;

    logic       ready;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       legal_op;
    logic       logimm_op;
    logic [2:0] imm_alu;

    assign ready     = HAS_MEMREADY ? bus.mem_ready : 1'b1;
    assign logimm_op = HAS_LOGIMM && (bus.opcode == OP_ANDI || bus.opcode == OP_ORI);
    assign imm_alu   = (bus.opcode == OP_ANDI) ? ALU_AND :
                       (bus.opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        legal_op = 1'b0;
        case (bus.opcode)
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: legal_op = 1'b1;
            OP_RTYPE:                                    legal_op = funct_ok;
            OP_ANDI, OP_ORI:                             legal_op = HAS_LOGIMM;
            default:                                     legal_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:  if (ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    if (!legal_op) begin
                        state_reg <= S_FETCH;
                    end else begin
                        case (bus.opcode)
                            OP_LW, OP_SW:              state_reg <= S_MEMADR;
                            OP_RTYPE:                  state_reg <= S_RTEX;
                            OP_BEQ:                    state_reg <= S_BEQ;
                            OP_BNE:                    state_reg <= S_BNE;
                            OP_ADDI, OP_ANDI, OP_ORI:  state_reg <= S_IMMEX;
                            OP_J:                      state_reg <= S_JMP;
                            default:                   state_reg <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: state_reg <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (ready) state_reg <= S_MEMWB;
                S_MEMWR:  if (ready) state_reg <= S_FETCH;
                S_RTEX:   state_reg <= S_RTWB;
                S_IMMEX:  state_reg <= S_IMMWB;
                default:  state_reg <= S_FETCH;
            endcase
        end
    end

    logic       memtoreg_c, regdst_c, iord_c, alusrca_c, irwrite_c, memwrite_c;
    logic       regwrite_c, pcen_c, zeroext_c, illegal_c, retire_c;
    logic       pcwrite_c, branch_c, branch_ne_c;
    logic [1:0] pcsrc_c, alusrcb_c;
    logic [2:0] alu3_c;
    logic [ALUCTRL_W-1:0] alu_full;

    // Reset presents FETCH decoding; the write enables are squashed afterwards.
    assign st = reset ? S_FETCH : state_reg;

    always_comb begin
        memtoreg_c  = 1'b0;
        regdst_c    = 1'b0;
        iord_c      = 1'b0;
        alusrca_c   = 1'b0;
        irwrite_c   = 1'b0;
        memwrite_c  = 1'b0;
        regwrite_c  = 1'b0;
        zeroext_c   = 1'b0;
        illegal_c   = 1'b0;
        retire_c    = 1'b0;
        pcwrite_c   = 1'b0;
        branch_c    = 1'b0;
        branch_ne_c = 1'b0;
        pcsrc_c     = 2'b00;
        alusrcb_c   = 2'b00;
        alu3_c      = 3'b000;
        case (st)
            S_FETCH: begin
                alusrcb_c = 2'b01;
                alu3_c    = ALU_ADD;
                irwrite_c = ready;
                pcwrite_c = ready;
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                alu3_c    = ALU_ADD;
                illegal_c = !legal_op;
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                alu3_c    = ALU_ADD;
            end
            S_MEMRD:  iord_c = 1'b1;
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                retire_c   = ready;
            end
            S_RTEX: begin
                alusrca_c = 1'b1;
                alu3_c    = funct_alu;
            end
            S_RTWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alusrca_c   = 1'b1;
                alu3_c      = ALU_SUB;
                pcsrc_c     = 2'b01;
                branch_c    = (st == S_BEQ);
                branch_ne_c = (st == S_BNE);
                retire_c    = 1'b1;
            end
            S_IMMEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                alu3_c    = imm_alu;
                zeroext_c = logimm_op;
            end
            S_IMMWB: begin
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
                zeroext_c  = logimm_op;
            end
            S_JMP: begin
                pcsrc_c   = 2'b10;
                pcwrite_c = 1'b1;
                retire_c  = 1'b1;
            end
            default: ;
        endcase
        pcen_c = pcwrite_c | (branch_c & bus.zero) | (branch_ne_c & ~bus.zero);
        if (reset) begin
            irwrite_c  = 1'b0;
            memwrite_c = 1'b0;
            regwrite_c = 1'b0;
            pcen_c     = 1'b0;
            illegal_c  = 1'b0;
            retire_c   = 1'b0;
        end
    end

    always_comb begin
        alu_full      = '0;
        alu_full[2:0] = alu3_c;
    end

    assign bus.memtoreg   = memtoreg_c;
    assign bus.regdst     = regdst_c;
    assign bus.iord       = iord_c;
    assign bus.pcsrc      = pcsrc_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.alusrca    = alusrca_c;
    assign bus.irwrite    = irwrite_c;
    assign bus.memwrite   = memwrite_c;
    assign bus.regwrite   = regwrite_c;
    assign bus.pcen       = pcen_c;
    assign bus.zeroext    = zeroext_c;
    assign bus.alucontrol = alu_full;
    assign bus.illegal    = illegal_c;
    assign bus.retire     = retire_c;
endmodule

// File: tb/tb_mc_controller_ext.sv
// Bench for mc_controller_ext: an instruction-level model expands each
// instruction into its expected per-cycle control word; dut2 covers W=5, no logimm.
module tb_mc_controller_ext;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_J = 6'b000010;

    typedef struct packed {
        logic       memtoreg;
        logic       regdst;
        logic       iord;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic       alusrca;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       pcen;
        logic       zeroext;
        logic [4:0] alu;
        logic       illegal;
        logic       retire;
    } outs_t;

    typedef struct {
        bit         rst;
        bit         dsel;
        logic [5:0] op;
        logic [5:0] fn;
        bit         z;
        bit         mr;
        outs_t      e;
        int         lat;
        int         tid;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_controller_ext_if #(.ALUCTRL_W(3)) b1 ();
    mc_controller_ext_if #(.ALUCTRL_W(5)) b2 ();

    mc_controller_ext #(.ALUCTRL_W(3), .HAS_MEMREADY(1'b1), .HAS_LOGIMM(1'b1)) dut (
        .clk(clk), .reset(rst), .bus(b1.master));
    mc_controller_ext #(.ALUCTRL_W(5), .HAS_MEMREADY(1'b1), .HAS_LOGIMM(1'b0)) dut2 (
        .clk(clk), .reset(rst), .bus(b2.master));

    vec_t  vq[$];
    string tname[$];
    int    checks = 0;
    int    errors = 0;
    logic [5:0] cur_op, cur_fn;
    bit    cur_dsel;

    function automatic outs_t o_fetch(bit rdy);
        outs_t o = '0;
        o.alusrcb = 2'b01;
        o.alu     = 5'b00010;
        o.irwrite = rdy;
        o.pcen    = rdy;
        return o;
    endfunction

    function automatic logic [4:0] alu_r(logic [5:0] fn);
        case (fn)
            6'b100000: return 5'b00010;
            6'b100010: return 5'b00110;
            6'b100100: return 5'b00000;
            6'b100101: return 5'b00001;
            default:   return 5'b00111;
        endcase
    endfunction

    function automatic bit is_legal(logic [5:0] op, logic [5:0] fn, bit logimm);
        if (op == OP_R)
            return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                   fn == 6'b100101 || fn == 6'b101010;
        if (op == OP_ANDI || op == OP_ORI) return logimm;
        return op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_BNE ||
               op == OP_ADDI || op == OP_J;
    endfunction

    task automatic push(bit r, bit z, bit mr, outs_t e);
        vec_t v;
        v.rst = r; v.dsel = cur_dsel; v.op = cur_op; v.fn = cur_fn;
        v.z = z; v.mr = mr; v.e = e; v.lat = 0; v.tid = 0;
        vq.push_back(v);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(int n);
        repeat (n) push(1'b1, rb(), rb(), o_fetch(1'b0));
    endtask

    // Expand one instruction into cycles; fw/mw = FETCH / memory wait cycles.
    task automatic instr(string nm, logic [5:0] op, logic [5:0] fn, bit z,
                         int fw, int mw, int lat);
        outs_t o;
        int    n0 = vq.size();
        bit    legal;
        cur_op = op; cur_fn = fn;
        legal = is_legal(op, fn, !cur_dsel);
        repeat (fw) push(1'b0, rb(), 1'b0, o_fetch(1'b0));
        push(1'b0, rb(), 1'b1, o_fetch(1'b1));
        o = '0; o.alusrcb = 2'b11; o.alu = 5'b00010; o.illegal = !legal;
        push(1'b0, rb(), rb(), o);
        if (legal) begin
            if (op == OP_LW || op == OP_SW) begin
                o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alu = 5'b00010;
                push(1'b0, rb(), rb(), o);
                o = '0; o.iord = 1'b1; o.memwrite = (op == OP_SW);
                repeat (mw) push(1'b0, rb(), 1'b0, o);
                o.retire = (op == OP_SW);
                push(1'b0, rb(), 1'b1, o);
                if (op == OP_LW) begin
                    o = '0; o.memtoreg = 1'b1; o.regwrite = 1'b1; o.retire = 1'b1;
                    push(1'b0, rb(), rb(), o);
                end
            end else if (op == OP_R) begin
                o = '0; o.alusrca = 1'b1; o.alu = alu_r(fn);
                push(1'b0, rb(), rb(), o);
                o = '0; o.regdst = 1'b1; o.regwrite = 1'b1; o.retire = 1'b1;
                push(1'b0, rb(), rb(), o);
            end else if (op == OP_BEQ || op == OP_BNE) begin
                o = '0; o.alusrca = 1'b1; o.alu = 5'b00110; o.pcsrc = 2'b01; o.retire = 1'b1;
                o.pcen = (op == OP_BEQ) ? z : !z;
                push(1'b0, z, rb(), o);
            end else if (op == OP_J) begin
                o = '0; o.pcsrc = 2'b10; o.pcen = 1'b1; o.retire = 1'b1;
                push(1'b0, rb(), rb(), o);
            end else begin
                o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
                o.zeroext = (op != OP_ADDI);
                o.alu = (op == OP_ADDI) ? 5'b00010 : (op == OP_ANDI) ? 5'b00000 : 5'b00001;
                push(1'b0, rb(), rb(), o);
                o = '0; o.regwrite = 1'b1; o.retire = 1'b1; o.zeroext = (op != OP_ADDI);
                push(1'b0, rb(), rb(), o);
            end
        end
        vq[vq.size()-1].lat = lat;
        vq[vq.size()-1].tid = tname.size();
        tname.push_back(nm);
        checks++;
        if (vq.size() - n0 != lat) begin
            errors++;
            $display("FAIL model_len %s got %0d exp %0d", nm, vq.size() - n0, lat);
        end
    endtask

    // Start a load/store and abort it with reset while it waits on memory.
    task automatic abort_mem(logic [5:0] op);
        outs_t o;
        cur_op = op; cur_fn = 6'b000000;
        push(1'b0, rb(), 1'b1, o_fetch(1'b1));
        o = '0; o.alusrcb = 2'b11; o.alu = 5'b00010;
        push(1'b0, rb(), rb(), o);
        o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alu = 5'b00010;
        push(1'b0, rb(), rb(), o);
        o = '0; o.iord = 1'b1; o.memwrite = (op == OP_SW);
        push(1'b0, rb(), 1'b0, o);
        cur_op = OP_J;
        do_reset(1);
    endtask

    initial begin
        logic [5:0] rfn[5];
        string      rnm[5];
        vec_t       v;
        outs_t      got;
        int         cnt;
        bit         ended;
        rfn[0] = 6'b100010; rfn[1] = 6'b100100; rfn[2] = 6'b100101;
        rfn[3] = 6'b101010; rfn[4] = 6'b100000;
        rnm[0] = "r_sub"; rnm[1] = "r_and"; rnm[2] = "r_or"; rnm[3] = "r_slt"; rnm[4] = "r_add";

        cur_dsel = 1'b0; cur_op = OP_LW; cur_fn = 6'b0;
        do_reset(2);
        instr("lw", OP_LW, 6'b0, 1'b0, 0, 0, 5);
        instr("sw_wait3", OP_SW, 6'b0, 1'b0, 0, 3, 7);
        instr("lw_fwait2", OP_LW, 6'b0, 1'b0, 2, 1, 8);
        for (int i = 0; i < 5; i++) instr(rnm[i], OP_R, rfn[i], 1'b0, 0, 0, 4);
        instr("beq_z1", OP_BEQ, 6'b0, 1'b1, 0, 0, 3);
        instr("beq_z0", OP_BEQ, 6'b0, 1'b0, 0, 0, 3);
        instr("bne_z0", OP_BNE, 6'b0, 1'b0, 0, 0, 3);
        instr("bne_z1", OP_BNE, 6'b0, 1'b1, 0, 0, 3);
        instr("andi", OP_ANDI, 6'b0, 1'b0, 0, 0, 4);
        instr("addi", OP_ADDI, 6'b0, 1'b0, 0, 0, 4);
        instr("ori", OP_ORI, 6'b0, 1'b0, 1, 0, 5);
        instr("j", OP_J, 6'b0, 1'b0, 0, 0, 3);
        instr("ill_op", 6'b111111, 6'b0, 1'b0, 0, 0, 2);
        instr("ill_fn", OP_R, 6'b000000, 1'b0, 0, 0, 2);
        abort_mem(OP_LW);
        instr("j_after", OP_J, 6'b0, 1'b0, 0, 0, 3);
        abort_mem(OP_SW);
        instr("sw", OP_SW, 6'b0, 1'b0, 0, 0, 4);

        cur_dsel = 1'b1;
        do_reset(1);
        instr("d2_sub", OP_R, 6'b100010, 1'b0, 0, 0, 4);
        instr("d2_slt", OP_R, 6'b101010, 1'b0, 0, 0, 4);
        instr("d2_ori", OP_ORI, 6'b0, 1'b0, 0, 0, 2);
        instr("d2_andi", OP_ANDI, 6'b0, 1'b0, 0, 0, 2);
        instr("d2_addi", OP_ADDI, 6'b0, 1'b0, 0, 0, 4);

        cnt = 0;
        foreach (vq[i]) begin
            v = vq[i];
            @(posedge clk);
            #1;
            rst = v.rst;
            b1.opcode = v.op; b1.funct = v.fn; b1.zero = v.z; b1.mem_ready = v.mr;
            b2.opcode = v.op; b2.funct = v.fn; b2.zero = v.z; b2.mem_ready = v.mr;
            @(negedge clk);
            if (v.dsel) begin
                got.memtoreg = b2.memtoreg; got.regdst = b2.regdst; got.iord = b2.iord;
                got.pcsrc = b2.pcsrc; got.alusrcb = b2.alusrcb; got.alusrca = b2.alusrca;
                got.irwrite = b2.irwrite; got.memwrite = b2.memwrite; got.regwrite = b2.regwrite;
                got.pcen = b2.pcen; got.zeroext = b2.zeroext; got.alu = b2.alucontrol;
                got.illegal = b2.illegal; got.retire = b2.retire;
            end else begin
                got.memtoreg = b1.memtoreg; got.regdst = b1.regdst; got.iord = b1.iord;
                got.pcsrc = b1.pcsrc; got.alusrcb = b1.alusrcb; got.alusrca = b1.alusrca;
                got.irwrite = b1.irwrite; got.memwrite = b1.memwrite; got.regwrite = b1.regwrite;
                got.pcen = b1.pcen; got.zeroext = b1.zeroext; got.alu = {2'b00, b1.alucontrol};
                got.illegal = b1.illegal; got.retire = b1.retire;
            end
            checks++;
            if (got !== v.e) begin
                errors++;
                $display("FAIL outputs cyc %0d dut%0d op %b got %h exp %h",
                         i, v.dsel + 1, v.op, got, v.e);
            end
            ended = got.retire | got.illegal;
            if (v.rst) cnt = 0;
            else cnt++;
            if (v.lat != 0) begin
                checks++;
                if (!ended || cnt != v.lat) begin
                    errors++;
                    $display("FAIL latency %s got %0d ended %0d exp %0d",
                             tname[v.tid], cnt, ended, v.lat);
                end
                $display("txn %s dut%0d cycles %0d", tname[v.tid], v.dsel + 1, cnt);
            end
            if (ended || v.rst) cnt = 0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_controller_ext.md
Name: mc_controller_ext

Overview:
- Parametrised next-generation control unit for the multi-cycle MIPS datapath. Contains a Moore main FSM and a combinational ALU decoder.
- Adds bne, addi, andi, ori and j to the lw/sw/R-type/beq set.
- Adds a memory wait-state handshake (mem_ready), an illegal-instruction flag and a retire pulse.
- Drives the same datapath select and enable signals as the current controller, plus a zero-extend select for logical immediates.

Parameters:
- ALUCTRL_W, 3, width of alucontrol; must be ≥3; bits above [2:0] are driven 0.
- HAS_MEMREADY, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- HAS_LOGIMM, 1, 1 = andi/ori decoded; 0 = their opcodes are illegal.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26], taken from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- memtoreg, regdst, iord  out  1  datapath selects
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alusrcb  out  2  00 B, 01 const 4, 10 signimm/zeroimm, 11 signimm<<2
- alusrca, irwrite, memwrite, regwrite, pcen  out  1  select and enables
- zeroext  out  1  1 = immediate is zero-extended
- alucontrol  out  ALUCTRL_W  ALU operation
- illegal  out  1  one-cycle pulse on an undecodable instruction
- retire  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- State register updates on the clk rising edge; reset=1 forces the next state to FETCH.
- While reset=1, irwrite, memwrite, regwrite, pcen, illegal and retire are forced to 0. All other outputs take FETCH values.
- Outputs are a combinational function of the state. alucontrol additionally depends on funct in RTEX and on opcode in IMMEX. Any output not listed for a state is 0.
- ALU codes: add 010, sub 110, and 000, or 001, slt 111.
- pcen = pcwrite | (branch & zero) | (branch_ne & ~zero).
- States, their outputs and next state:
  - FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
    - irwrite=pcwrite=mem_ready (gated by HAS_MEMREADY).
    - Stays in FETCH while !mem_ready; otherwise goes to DECODE.
  - DECODE: alusrca=0, alusrcb=11, add.
    - lw/sw (100011/101011) → MEMADR; R-type 000000 → RTEX; beq 000100 → BEQ; bne 000101 → BNE.
    - addi 001000, andi 001100, ori 001101 → IMMEX; j 000010 → JMP.
    - Any other opcode, or R-type with funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt}: illegal=1 → FETCH, with no register, memory or PC write.
  - MEMADR: alusrca=1, alusrcb=10, add → MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1; waits for mem_ready → MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1, retire=1 → FETCH.
  - MEMWR: iord=1, memwrite=1 held until mem_ready; retire=1 on the mem_ready cycle → FETCH.
  - RTEX: alusrca=1, alusrcb=00, alucontrol from funct → RTWB.
  - RTWB: regdst=1, memtoreg=0, regwrite=1, retire=1 → FETCH.
  - BEQ: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1, retire=1 → FETCH.
  - BNE: same as BEQ but with branch_ne=1 instead of branch → FETCH.
  - IMMEX: alusrca=1, alusrcb=10.
    - addi: add, zeroext=0.
    - andi: and, zeroext=1.
    - ori: or, zeroext=1.
    - → IMMWB.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1, retire=1; zeroext holds its IMMEX value → FETCH.
  - JMP: pcsrc=10, pcwrite=1, retire=1 → FETCH.
- Latency in cycles with mem_ready always 1:
  - lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3, illegal 2.
  - Each !mem_ready cycle adds one cycle.
- Reset asserted in any state, including mid-wait in MEMWR, reaches FETCH on the next edge. memwrite is 0 during the reset cycle.
- Unreachable state encodings → FETCH.

Test Plan:
1. reset=1 for 2 cycles, then opcode=100011 with mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5; retire is a single pulse; enables are 0 during reset.
2. sw (101011) with mem_ready=0 for 3 cycles in MEMWR → memwrite=1 for 4 cycles, retire only on the 4th; FETCH with mem_ready=0 for 2 cycles → irwrite/pcen=0, then 1.
3. R-type with funct 100010/100100/100101/101010/100000 → alucontrol 110/000/001/111/010 in RTEX; regdst=1 in RTWB; with ALUCTRL_W=5 the upper bits are 0.
4. beq with zero=1 → pcen=1 and pcsrc=01; beq with zero=0 → pcen=0; bne with zero=0 → pcen=1; bne with zero=1 → pcen=0.
5. andi (001100) → zeroext=1, alucontrol=000; addi → zeroext=0, 010; HAS_LOGIMM=0 with ori → illegal pulse, back in FETCH after 2 cycles, regwrite never 1.
6. j (000010) → pcsrc=10, pcen=1 in the 3rd cycle; opcode 111111 → illegal=1 in DECODE; reset asserted in MEMRD → FETCH on the next edge.
